// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit frame path.
// Used by uart_tx_frame and parity_calc; the RX path can reuse the parity constants.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: even parity is the XOR of all data bits,
// odd parity is its inverse. Shared between the TX and RX paths.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : ^data;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame controller: start/data/[parity]/stop sequencing around an
// external Serializer, with a bit-count watchdog. Parity is built with UART_TX_PARITY_EN.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_TYP,
  input  logic                  ser_out,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state;
  state_t                  data_exit;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    accept;
  logic                    watchdog;
  logic                    next_line;

`ifdef UART_TX_PARITY_EN
  logic par_typ_reg;
  logic par_bit;

  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_reg),
    .par_typ (par_typ_reg),
    .par_bit (par_bit)
  );

  assign data_exit = ST_PARITY;
`else
  logic unused_par_bit;
  logic unused_par_typ;

  // Kept elaborated so the shared generator is present in every build; its
  // result has no consumer without the parity bit.
  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (data_reg),
    .par_typ (PAR_EVEN),
    .par_bit (unused_par_bit)
  );

  assign unused_par_typ = PAR_TYP;
  assign data_exit      = ST_STOP;
`endif

  assign accept   = Data_Valid && ((state == ST_IDLE) || (state == ST_STOP));
  assign watchdog = (bit_cnt == WD_LAST) && !ser_done;
  assign ser_en   = (state == ST_DATA);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    next_line = LINE_IDLE;
    case (state)
      ST_IDLE:   next_line = LINE_IDLE;
      ST_START:  next_line = START_BIT;
      ST_DATA:   next_line = ser_out;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: next_line = par_bit;
`endif
      ST_STOP:   next_line = STOP_BIT;
      default:   next_line = LINE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its sources regardless of order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      TX_OUT    <= LINE_IDLE;
      Busy      <= 1'b0;
      frame_err <= 1'b0;
      // NOTE: the data register is plain flops, not a memory, so it takes a
      // defined reset value like the rest of the control state.
      data_reg  <= '0;
      bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      par_typ_reg <= PAR_EVEN;
`endif
    end else begin
      TX_OUT <= next_line;
      Busy   <= (state != ST_IDLE);

      if (accept) begin
        data_reg  <= P_DATA;
        frame_err <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_typ_reg <= PAR_TYP;
`endif
      end

      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_START;
        end
        ST_START: begin
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          // ser_done wins over the watchdog when both fire in the same cycle.
          if (ser_done) begin
            state <= data_exit;
          end else if (watchdog) begin
            frame_err <= 1'b1;
            state     <= data_exit;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: state <= ST_STOP;
`endif
        ST_STOP: begin
          state <= accept ? ST_START : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with a Serializer stub and a per-cycle
// scoreboard of expected TX_OUT/Busy values.
module tb_uart_tx_frame;

  localparam int N = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = N + 2 + PAR;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_TYP;
  logic         ser_out;
  logic         ser_done;
  logic         ser_en;
  logic         TX_OUT;
  logic         Busy;
  logic         frame_err;

  uart_tx_frame #(.DATA_WIDTH(N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_TYP    (PAR_TYP),
    .ser_out    (ser_out),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  // Serializer stub: presents stub_data LSB-first while enabled.
  logic [N-1:0] stub_data;
  logic         stub_done_en;
  int           idx = 0;

  always @(posedge CLK) begin
    if (ser_en) idx <= idx + 1;
    else        idx <= 0;
  end

  assign ser_out  = stub_data[idx[2:0]];
  assign ser_done = stub_done_en && (idx == N - 1);

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ser_en_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic tx, input logic busy);
    exp_t e;
    e.tx   = tx;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  // lead: the accept edge itself (idle line); trail: the first idle cycle after stop.
  task automatic push_frame(input logic [N-1:0] d, input logic pt, input bit lead, input bit trail);
    if (lead) push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b1);
    for (int i = 0; i < N; i++) push_exp(d[i], 1'b1);
    if (PAR == 1) push_exp((^d) ^ pt, 1'b1);
    push_exp(1'b1, 1'b1);
    if (trail) push_exp(1'b1, 1'b0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    if (ser_en) ser_en_cycles++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tx_out", TX_OUT, e.tx);
      check("busy", Busy, e.busy);
    end
  endtask

  task automatic send(input logic [N-1:0] d, input logic pt);
    P_DATA     = d;
    PAR_TYP    = pt;
    stub_data  = d;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    repeat (n) tick();
    check("sb_empty", exp_q.size(), 0);
  endtask

  task automatic run_frame(input logic [N-1:0] d, input logic pt);
    push_frame(d, pt, 1'b1, 1'b1);
    ser_en_cycles = 0;
    send(d, pt);
    drain();
    check("data_cycles", ser_en_cycles, N);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RST          = 1'b1;
    Data_Valid   = 1'b0;
    PAR_TYP      = 1'b0;
    P_DATA       = '0;
    stub_data    = '0;
    stub_done_en = 1'b1;

    // Reset state, then idle.
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_ser_en", ser_en, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_exp(1'b1, 1'b0);
      tick();
      check("idle_ser_en", ser_en, 1'b0);
      check("idle_frame_err", frame_err, 1'b0);
    end

    // Single frames with different data and parity types.
    run_frame(8'hA5, 1'b0);
    check("a5_frame_err", frame_err, 1'b0);
    run_frame(8'h03, 1'b1);
    run_frame(8'h07, 1'b1);
    check("par_frame_err", frame_err, 1'b0);

    // Back-to-back: second request lands on the first frame's stop cycle.
    push_frame(8'h55, 1'b0, 1'b1, 1'b0);
    push_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    ser_en_cycles = 0;
    send(8'h55, 1'b0);
    repeat (L - 1) tick();
    send(8'h0F, 1'b0);
    drain();
    check("b2b_data_cycles", ser_en_cycles, 2 * N);

    // Watchdog: ser_done never arrives.
    stub_done_en = 1'b0;
    run_frame(8'h3C, 1'b0);
    check("wd_frame_err", frame_err, 1'b1);
    push_exp(1'b1, 1'b0);
    push_exp(1'b1, 1'b0);
    tick();
    tick();
    check("wd_sticky", frame_err, 1'b1);
    stub_done_en = 1'b1;
    push_frame(8'h81, 1'b1, 1'b1, 1'b1);
    send(8'h81, 1'b1);
    check("wd_cleared", frame_err, 1'b0);
    drain();

    // Requests during START and DATA are ignored.
    push_frame(8'h96, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0);
    send(8'h96, 1'b0);
    P_DATA     = 8'hFE;
    Data_Valid = 1'b1;
    tick();
    tick();
    tick();
    Data_Valid = 1'b0;
    drain();

    // Reset on the 4th data bit, with Data_Valid asserted alongside.
    push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b1);
    push_exp(1'b0, 1'b1);
    push_exp(1'b1, 1'b1);
    push_exp(1'b1, 1'b1);
    push_exp(1'b1, 1'b0);
    push_exp(1'b1, 1'b0);
    send(8'h36, 1'b0);
    repeat (4) tick();
    RST        = 1'b1;
    Data_Valid = 1'b1;
    tick();
    check("abort_ser_en", ser_en, 1'b0);
    tick();
    RST        = 1'b0;
    Data_Valid = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0);
    drain();
    check("abort_idle_ser_en", ser_en, 1'b0);

    // Normal operation after the abort.
    run_frame(8'h5A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
